// File: rtl/stlc_pkg.sv
// Shared types and constants for the small traffic-light controller and its input conditioning.
package stlc_pkg;

   localparam int unsigned STLC_DEBOUNCE_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_REQ   = 2'b01,
      S_SERVE = 2'b10
   } sense_state_t;

endpackage : stlc_pkg

// File: rtl/stlc_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce filter.
module stlc_debounce
   import stlc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = STLC_DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // The filtered level flips only after the new level persists for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            dout <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule : stlc_debounce

// File: rtl/stlc_sensor_cond.sv
// Loop-detector conditioning: debounce, arrival detection, request/acknowledge FSM and arrival count.
module stlc_sensor_cond
   import stlc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = STLC_DEBOUNCE_DEF,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             loop_raw,
   input  logic             g_light,
   input  logic             count_clr,
   output logic             sensor,
   output logic             veh_present,
   output logic [CNT_W-1:0] veh_count
);

   logic         filt;
   logic         filt_d;
   logic         arr_c;
   logic         pend;
   logic         pend_nxt;
   logic         sensor_nxt;
   sense_state_t state;
   sense_state_t state_nxt;

   stlc_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (loop_raw),
      .dout  (filt)
   );

   assign veh_present = filt;
   assign arr_c       = filt & ~filt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_d <= 1'b0;
      end else begin
         filt_d <= filt;
      end
   end

   // Saturating arrival counter; clear wins over a coincident arrival.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         veh_count <= '0;
      end else if (count_clr) begin
         veh_count <= '0;
      end else if (arr_c && (veh_count != '1)) begin
         veh_count <= veh_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pend   <= 1'b0;
         sensor <= 1'b0;
      end else begin
         state  <= state_nxt;
         pend   <= pend_nxt;
         sensor <= sensor_nxt;
      end
   end

   // Arrivals during green are remembered so the request is re-raised once green ends.
   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      case (state)
         S_IDLE: begin
            if (arr_c) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (g_light) begin
               state_nxt = S_SERVE;
            end
         end
         S_SERVE: begin
            if (arr_c) begin
               pend_nxt = 1'b1;
            end
            if (!g_light) begin
               state_nxt = (pend || filt || arr_c) ? S_REQ : S_IDLE;
               pend_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            pend_nxt  = 1'b0;
         end
      endcase
   end

   // sensor is registered alongside state so it always equals (state == S_REQ).
   always_comb begin
      sensor_nxt = 1'b0;
      if (state_nxt == S_REQ) begin
         sensor_nxt = 1'b1;
      end
   end

endmodule : stlc_sensor_cond

// File: tb/tb_stlc_sensor_cond.sv
// Directed bench for stlc_sensor_cond with hand-computed expectations (DEBOUNCE_CYCLES=4, CNT_W=2).
module tb_stlc_sensor_cond;

   localparam int unsigned DB = 4;
   localparam int unsigned CW = 2;

   logic          clk;
   logic          rst_n;
   logic          loop_raw;
   logic          g_light;
   logic          count_clr;
   logic          sensor;
   logic          veh_present;
   logic [CW-1:0] veh_count;

   int n_vec;
   int n_err;

   stlc_sensor_cond #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .loop_raw    (loop_raw),
      .g_light     (g_light),
      .count_clr   (count_clr),
      .sensor      (sensor),
      .veh_present (veh_present),
      .veh_count   (veh_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      loop_raw  = 1'b0;
      g_light   = 1'b0;
      count_clr = 1'b0;
      #12;
      chk("rst_sensor", 32'(sensor), 32'd0);
      chk("rst_present", 32'(veh_present), 32'd0);
      chk("rst_count", 32'(veh_count), 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Bounce rejection: 1, 2, 3-cycle pulses with 4 low cycles between
      for (int p = 1; p <= 3; p++) begin
         loop_raw = 1'b1;
         tick(p);
         loop_raw = 1'b0;
         tick(4);
      end
      tick(4);
      chk("bounce_present", 32'(veh_present), 32'd0);
      chk("bounce_sensor", 32'(sensor), 32'd0);
      chk("bounce_count", 32'(veh_count), 32'd0);

      // Clean arrival: loop_raw rises before edge 1
      loop_raw = 1'b1;
      tick(5);
      chk("arr_present_e5", 32'(veh_present), 32'd0);
      tick(1);
      chk("arr_present_e6", 32'(veh_present), 32'd1);
      chk("arr_sensor_e6", 32'(sensor), 32'd0);
      tick(1);
      chk("arr_sensor_e7", 32'(sensor), 32'd1);
      chk("arr_count_e7", 32'(veh_count), 32'd1);
      tick(13);
      chk("arr_sensor_e20", 32'(sensor), 32'd1);
      chk("arr_count_e20", 32'(veh_count), 32'd1);

      // Acknowledge after the vehicle has departed -> back to idle
      loop_raw = 1'b0;
      tick(10);
      chk("dep_present", 32'(veh_present), 32'd0);
      chk("dep_sensor_held", 32'(sensor), 32'd1);
      g_light = 1'b1;
      tick(1);
      chk("ack0_sensor_k", 32'(sensor), 32'd0);
      g_light = 1'b0;
      tick(3);
      chk("ack0_sensor_idle", 32'(sensor), 32'd0);

      // Acknowledge while the vehicle is still present -> request re-raised
      loop_raw = 1'b1;
      tick(7);
      chk("arr2_sensor", 32'(sensor), 32'd1);
      chk("arr2_count", 32'(veh_count), 32'd2);
      g_light = 1'b1;
      tick(1);
      chk("ack1_sensor_k", 32'(sensor), 32'd0);
      g_light = 1'b0;
      tick(2);
      chk("ack1_sensor_k2", 32'(sensor), 32'd1);

      // Arrival during green is remembered via pend
      loop_raw = 1'b0;
      tick(10);
      g_light = 1'b1;
      tick(1);
      chk("green_sensor", 32'(sensor), 32'd0);
      loop_raw = 1'b1;
      tick(7);
      chk("green_arr_count", 32'(veh_count), 32'd3);
      chk("green_arr_sensor", 32'(sensor), 32'd0);
      loop_raw = 1'b0;
      tick(10);
      chk("green_dep_present", 32'(veh_present), 32'd0);
      chk("green_still_serve", 32'(sensor), 32'd0);
      g_light = 1'b0;
      tick(1);
      chk("pend_sensor", 32'(sensor), 32'd1);

      // Saturation: arrivals 4 and 5 hold the 2-bit count at 3
      for (int a = 0; a < 2; a++) begin
         loop_raw = 1'b1;
         tick(8);
         loop_raw = 1'b0;
         tick(8);
      end
      chk("sat_count", 32'(veh_count), 32'd3);
      chk("sat_sensor", 32'(sensor), 32'd1);

      // Asynchronous reset mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sensor", 32'(sensor), 32'd0);
      chk("arst_present", 32'(veh_present), 32'd0);
      chk("arst_count", 32'(veh_count), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      loop_raw = 1'b1;
      tick(7);
      chk("post_rst_sensor", 32'(sensor), 32'd1);
      chk("post_rst_count", 32'(veh_count), 32'd1);

      // Clear coincident with an arrival pulse wins
      loop_raw = 1'b0;
      tick(10);
      loop_raw = 1'b1;
      tick(6);
      chk("clr_present_e6", 32'(veh_present), 32'd1);
      count_clr = 1'b1;
      tick(1);
      count_clr = 1'b0;
      chk("clr_count", 32'(veh_count), 32'd0);
      tick(2);
      chk("clr_count_hold", 32'(veh_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_stlc_sensor_cond
